// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the image-decryption CPU: opcodes, field positions, widths.
// No logic here; pure types, constants and a sign-extension helper.
// Consumers import with cpu_pkg::*.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int DMEM_AW = 14;

  // Instruction field positions: [31:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 24;
  localparam int RS1_MSB = 23;
  localparam int RS1_LSB = 20;
  localparam int RS2_MSB = 19;
  localparam int RS2_LSB = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_MUL  = 4'h3,
    OP_REM  = 4'h4,
    OP_AND  = 4'h5,
    OP_SHR  = 4'h6,
    OP_XOR  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LDB  = 4'h9,
    OP_STB  = 4'hA,
    OP_BEQ  = 4'hB,
    OP_BNE  = 4'hC,
    OP_JMP  = 4'hD,
    OP_RSW  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Register-register ALU for ADD..XOR; all results wrap modulo 2^32.
// Purely combinational, zero latency.
// No flow control; result is valid whenever the inputs are.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  // Select the operation; remainder by zero passes the dividend through
  always_comb begin
    y = '0;
    case (opcode_t'(op))
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_REM:  y = (b == '0) ? a : (a % b);
      OP_AND:  y = a & b;
      OP_SHR:  y = a >> b[4:0];
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/decrypt_cpu.sv
// Single-cycle 32-bit CPU decrypting an image in its byte RAM; GPU reads RAM through a second async port.
// One instruction per cycle; loads see stores from the previous cycle; GPU port is combinational.
// No backpressure; HALT freezes PC/regs/RAM until rst. CPU_DEBUG_PORT_EN adds dbg_pc/dbg_halted.
module decrypt_cpu
  import cpu_pkg::*;
#(
  parameter string PROG_FILE  = "program.hex",
  parameter string DATA_FILE  = "image.hex",
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  switch,
  input  logic [31:0] GPUAddress,
  output logic [31:0] GPUData
`ifdef CPU_DEBUG_PORT_EN
  ,
  output logic [7:0]  dbg_pc,
  output logic        dbg_halted
`endif
);

  localparam int PC_W = $clog2(IMEM_DEPTH);

  logic [XLEN-1:0]    imem [0:IMEM_DEPTH-1];
  logic [7:0]         dmem [0:DMEM_DEPTH-1];
  logic [XLEN-1:0]    regs [0:15];

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    next_pc;
  logic               halted;
  logic               set_halt;

  logic [XLEN-1:0]    instr;
  opcode_t            op;
  logic [3:0]         rd;
  logic [3:0]         rs1;
  logic [3:0]         rs2;
  logic [15:0]        imm;
  logic [XLEN-1:0]    imm_sx;
  logic [XLEN-1:0]    rv1;
  logic [XLEN-1:0]    rv2;
  logic [XLEN-1:0]    eff;
  logic [DMEM_AW-1:0] daddr;
  logic [XLEN-1:0]    alu_y;
  logic [XLEN-1:0]    wr_dat;
  logic               wr_en;
  logic               st_en;
  logic               unused_bits;

  // Memories power up cleared
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
    for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = '0;
  end

  assign instr  = imem[pc];
  assign op     = opcode_t'(instr[OP_MSB:OP_LSB]);
  assign rd     = instr[RD_MSB:RD_LSB];
  assign rs1    = instr[RS1_MSB:RS1_LSB];
  assign rs2    = instr[RS2_MSB:RS2_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];
  assign imm_sx = sext16(imm);

  // r0 is hardwired to zero on the read side as well
  assign rv1    = (rs1 == 4'd0) ? '0 : regs[rs1];
  assign rv2    = (rs2 == 4'd0) ? '0 : regs[rs2];

  // Effective address / ADDI sum; RAM addressing wraps on the low 14 bits
  assign eff    = rv1 + imm_sx;
  assign daddr  = eff[DMEM_AW-1:0];

  assign GPUData     = {24'b0, dmem[GPUAddress[DMEM_AW-1:0]]};
  assign unused_bits = ^{eff[XLEN-1:DMEM_AW], GPUAddress[31:DMEM_AW]};

  cpu_alu u_alu (
    .op (instr[OP_MSB:OP_LSB]),
    .a  (rv1),
    .b  (rv2),
    .y  (alu_y)
  );

  // Decode: writeback select, store enable and next PC; a halted core holds everything
  always_comb begin
    next_pc  = pc + PC_W'(1);
    wr_en    = 1'b0;
    wr_dat   = alu_y;
    st_en    = 1'b0;
    set_halt = 1'b0;
    if (halted) begin
      next_pc = pc;
    end else begin
      case (op)
        OP_NOP: ;
        OP_ADD, OP_SUB, OP_MUL, OP_REM,
        OP_AND, OP_SHR, OP_XOR: wr_en = 1'b1;
        OP_ADDI: begin
          wr_en  = 1'b1;
          wr_dat = eff;
        end
        OP_LDB: begin
          wr_en  = 1'b1;
          wr_dat = {24'b0, dmem[daddr]};
        end
        OP_STB: st_en = 1'b1;
        OP_BEQ: if (rv1 == rv2) next_pc = pc + imm_sx[PC_W-1:0];
        OP_BNE: if (rv1 != rv2) next_pc = pc + imm_sx[PC_W-1:0];
        OP_JMP: next_pc = imm[PC_W-1:0];
        OP_RSW: begin
          wr_en  = 1'b1;
          wr_dat = {23'b0, switch};
        end
        OP_HALT: begin
          set_halt = 1'b1;
          next_pc  = pc;
        end
        default: ;
      endcase
    end
  end

  // PC, halt flag and register file; r0 writes are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      halted <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      pc     <= next_pc;
      halted <= halted | set_halt;
      if (wr_en && (rd != 4'd0)) regs[rd] <= wr_dat;
    end
  end

  // Byte store; contents survive reset and a store in a reset cycle is dropped
  always_ff @(posedge clk) begin
    if (!rst && st_en) dmem[daddr] <= rv2[7:0];
  end

`ifdef CPU_DEBUG_PORT_EN
  assign dbg_pc     = 8'(pc);
  assign dbg_halted = halted;
`endif

endmodule

// File: tb/tb_decrypt_cpu.sv
// Directed + randomized bench for decrypt_cpu with an instruction-level reference model.
// Model executes one instruction per clock in lockstep with the DUT.
// GPU port is checked combinationally; all checks are immediate assertions.
module tb_decrypt_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  switch;
  logic [31:0] gpu_addr;
  logic [31:0] gpu_data;
`ifdef CPU_DEBUG_PORT_EN
  logic [7:0]  dbg_pc;
  logic        dbg_halted;
`endif

  always #5 clk = ~clk;

  decrypt_cpu #(
    .PROG_FILE  (""),
    .DATA_FILE  (""),
    .IMEM_DEPTH (256),
    .DMEM_DEPTH (16384)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .switch     (switch),
    .GPUAddress (gpu_addr),
    .GPUData    (gpu_data)
`ifdef CPU_DEBUG_PORT_EN
    ,
    .dbg_pc     (dbg_pc),
    .dbg_halted (dbg_halted)
`endif
  );

  int          checks;
  int          errors;

  // Reference model state
  logic [31:0] prog  [256];
  bit   [31:0] m_r   [16];
  bit   [7:0]  m_mem [16384];
  int unsigned m_pc;
  bit          m_halt;
  int          st_q [$];

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
    logic [31:0] o, d, s1, s2, im;
    o = op; d = rd; s1 = rs1; s2 = rs2; im = imm;
    return {o[3:0], d[3:0], s1[3:0], s2[3:0], im[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 0;
    m_halt = 1'b0;
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    st_q.delete();
  endtask

  // One architectural instruction, straight from the ISA description
  task automatic m_step();
    logic [31:0] w, a, b, sx, res, ea;
    int op, rd, addr;
    int unsigned npc;
    bit wr;
    if (m_halt) return;
    w   = prog[m_pc];
    op  = int'(w[31:28]);
    rd  = int'(w[27:24]);
    a   = m_r[w[23:20]];
    b   = m_r[w[19:16]];
    sx  = {{16{w[15]}}, w[15:0]};
    ea  = a + sx;
    npc = (m_pc + 1) % 256;
    wr  = 1'b1;
    res = '0;
    case (op)
      1:  res = a + b;
      2:  res = a - b;
      3:  res = a * b;
      4:  res = (b == 0) ? a : a % b;
      5:  res = a & b;
      6:  res = a >> b[4:0];
      7:  res = a ^ b;
      8:  res = ea;
      9:  res = {24'b0, m_mem[ea % 16384]};
      10: begin wr = 1'b0; addr = int'(ea % 16384); m_mem[addr] = b[7:0]; st_q.push_back(addr); end
      11: begin wr = 1'b0; if (a == b) npc = (m_pc + sx) % 256; end
      12: begin wr = 1'b0; if (a != b) npc = (m_pc + sx) % 256; end
      13: begin wr = 1'b0; npc = int'(w[7:0]); end
      14: res = {23'b0, switch};
      15: begin wr = 1'b0; m_halt = 1'b1; npc = m_pc; end
      default: wr = 1'b0;
    endcase
    if (wr && rd != 0) m_r[rd] = res;
    m_pc = npc;
  endtask

  task automatic load(input logic [31:0] q[$]);
    for (int i = 0; i < 256; i++) begin
      prog[i] = (i < q.size()) ? q[i] : 32'h0;
      dut.imem[i] = prog[i];
    end
  endtask

  task automatic start();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_step();
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".pc"}, 32'(dut.pc), m_pc);
    chk({tag, ".halted"}, 32'(dut.halted), 32'(m_halt));
    for (int i = 1; i < 16; i++)
      chk($sformatf("%s.r%0d", tag, i), dut.regs[i], m_r[i]);
  endtask

  task automatic run_to_halt(input string tag, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (m_halt) break;
      tick();
    end
    checks++;
    assert (m_halt) else begin
      errors++;
      $error("FAIL %s.timeout observed=running expected=halted", tag);
    end
    check_state(tag);
  endtask

  task automatic gpu_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    gpu_addr = addr;
    #1;
    chk(tag, gpu_data, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=no-finish expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] hi;
    int ol [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 14};
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    switch   = '0;
    gpu_addr = '0;
    #1;

    // Reset and halt hold
    q = {enc(8, 1, 0, 0, 5), enc(15, 0, 0, 0, 0)};
    load(q);
    start();
    check_state("reset");
    repeat (3) tick();
    chk("t1.r1", dut.regs[1], 32'd5);
    chk("t1.pc", 32'(dut.pc), 32'd1);
    check_state("t1");
    rst = 1'b1;
    @(posedge clk); #1;
    m_reset();
    chk("t1.rst_r1", dut.regs[1], 32'd0);
    chk("t1.rst_pc", 32'(dut.pc), 32'd0);

    // Store at top byte, GPU sees old byte until the edge, wrap on GPU address
    q = {enc(8, 1, 0, 0, 'hAB), enc(10, 0, 0, 1, 16383), enc(15, 0, 0, 0, 0)};
    load(q);
    gpu_addr = 32'd16383;
    start();
    tick();
    gpu_chk("t2.before_edge", 32'd16383, 32'h0);
    tick();
    gpu_chk("t2.after_edge", 32'd16383, 32'hAB);
    gpu_chk("t2.wrap", 32'd32767, 32'hAB);
    run_to_halt("t2", 20);

    // Switch key readback
    switch = 9'b000010101;
    q = {enc(14, 2, 0, 0, 0), enc(10, 0, 0, 2, 0), enc(15, 0, 0, 0, 0)};
    load(q);
    start();
    run_to_halt("t3", 20);
    gpu_chk("t3.gpu0", 32'd0, 32'h15);

    // 4^13 mod 497 by square-and-multiply
    q = {enc(8, 1, 0, 0, 4), enc(8, 2, 0, 0, 13), enc(8, 3, 0, 0, 497),
         enc(8, 4, 0, 0, 1), enc(8, 5, 0, 0, 1),
         enc(5, 6, 2, 5, 0), enc(11, 0, 6, 0, 3),
         enc(3, 4, 4, 1, 0), enc(4, 4, 4, 3, 0),
         enc(3, 1, 1, 1, 0), enc(4, 1, 1, 3, 0),
         enc(6, 2, 2, 5, 0), enc(12, 0, 2, 0, -7),
         enc(10, 0, 0, 4, 1), enc(15, 0, 0, 0, 0)};
    load(q);
    start();
    run_to_halt("t4", 500);
    chk("t4.r4", dut.regs[4], 32'd445);
    gpu_chk("t4.gpu1", 32'd1, 32'hBD);

    // Seed bytes 0..3 then XOR-decrypt them in place with switch[7:0]
    switch = 9'h015;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      q.push_back(enc(8, 1, 0, 0, i + 1));
      q.push_back(enc(10, 0, 0, 1, i));
    end
    q.push_back(enc(14, 2, 0, 0, 0));
    q.push_back(enc(8, 7, 0, 0, 255));
    q.push_back(enc(5, 2, 2, 7, 0));
    q.push_back(enc(8, 3, 0, 0, 0));
    q.push_back(enc(8, 4, 0, 0, 4));
    q.push_back(enc(9, 5, 3, 0, 0));
    q.push_back(enc(7, 5, 5, 2, 0));
    q.push_back(enc(10, 0, 3, 5, 0));
    q.push_back(enc(8, 3, 3, 0, 1));
    q.push_back(enc(12, 0, 3, 4, -4));
    q.push_back(enc(15, 0, 0, 0, 0));
    load(q);
    start();
    run_to_halt("t5", 200);
    gpu_chk("t5.b0", 32'd0, 32'h14);
    gpu_chk("t5.b1", 32'd1, 32'h17);
    gpu_chk("t5.b2", 32'd2, 32'h16);
    gpu_chk("t5.b3", 32'd3, 32'h11);

    // Self-branch spin never halts and never moves
    q = {enc(11, 0, 0, 0, 0)};
    load(q);
    start();
    repeat (10) tick();
    chk("t6.spin_pc", 32'(dut.pc), 32'd0);
    chk("t6.spin_halted", 32'(dut.halted), 32'd0);

    // MUL wrap, REM by zero, r0 write discarded, JMP over dead code
    q = {enc(8, 1, 0, 0, -1), enc(8, 2, 0, 0, 2), enc(3, 3, 1, 2, 0),
         enc(4, 4, 2, 0, 0), enc(8, 0, 0, 0, 7), enc(1, 5, 0, 0, 0),
         enc(13, 0, 0, 0, 8), enc(8, 6, 0, 0, 9), enc(8, 7, 0, 0, 3),
         enc(15, 0, 0, 0, 0)};
    load(q);
    start();
    run_to_halt("t6", 50);
    chk("t6.mul", dut.regs[3], 32'hFFFFFFFE);
    chk("t6.rem0", dut.regs[4], 32'd2);
    chk("t6.r0", dut.regs[5], 32'd0);
    chk("t6.jmp_skip", dut.regs[6], 32'd0);
    chk("t6.jmp_land", dut.regs[7], 32'd3);

    // Reset during a store cycle suppresses the store
    q = {enc(8, 1, 0, 0, 'h5A), enc(10, 0, 0, 1, 100), enc(15, 0, 0, 0, 0)};
    load(q);
    start();
    tick();
    rst = 1'b1;
    @(posedge clk); #1;
    m_reset();
    gpu_chk("t7.suppressed", 32'd100, 32'h0);
    chk("t7.pc", 32'(dut.pc), 32'd0);
    rst = 1'b0;
    run_to_halt("t7", 20);
    gpu_chk("t7.stored", 32'd100, 32'h5A);

    // Randomized straight-line programs against the model
    for (int t = 0; t < 6; t++) begin
      switch = 9'($urandom);
      q.delete();
      for (int r = 1; r <= 4; r++) q.push_back(enc(8, r, 0, 0, int'($urandom_range(0, 65535))));
      for (int k = 0; k < 16; k++)
        q.push_back(enc(ol[$urandom_range(0, 11)], int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom)));
      q.push_back(enc(15, 0, 0, 0, 0));
      load(q);
      start();
      run_to_halt($sformatf("rnd%0d", t), 100);
      foreach (st_q[i]) begin
        hi = $urandom & 32'hFFFFC000;
        gpu_chk($sformatf("rnd%0d.gpu%0d", t, st_q[i]), hi | 32'(st_q[i]), {24'b0, m_mem[st_q[i]]});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
